alu_mdu: RTL and testbench

Parametrised successor to the datapath ALU: the same 4-bit combinational operation set generalised to `WIDTH` bits, plus an iterative multiply/divide unit with architectural HI/LO registers and a start/busy handshake. It sits in the EX stage. `C`/`Overflow` serve ALU-class instructions in the same cycle. MULT/MULTU/DIV/DIVU/MTHI/MTLO are issued through `md_start`, and the pipeline stalls MFHI/MFLO and new MD ops while `busy` is high.

---
 rtl/alu_mdu.sv | 175 +++++++++++++++++
 tb/tb_alu_mdu.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// EX-stage datapath: combinational ALU plus an iterative multiply/divide unit
// that owns the architectural HI/LO registers behind a start/busy handshake.
module alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Op,
    output logic [WIDTH-1:0] C,
    output logic             Overflow,
    input  logic             md_start,
    input  logic [2:0]       md_op,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;
    localparam int HW = WIDTH / 2;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} md_state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        return neg_w(v, sgn & v[WIDTH-1]);
    endfunction

    logic [SW-1:0]           shamt;
    logic signed [WIDTH:0]   add_x;
    logic signed [WIDTH:0]   sub_x;

    assign shamt = A[SW-1:0];
    assign add_x = $signed({A[WIDTH-1], A}) + $signed({B[WIDTH-1], B});
    assign sub_x = $signed({A[WIDTH-1], A}) - $signed({B[WIDTH-1], B});

    always_comb begin
        C        = '0;
        Overflow = 1'b0;
        case (Op)
            4'b0000: C = add_x[WIDTH-1:0];
            4'b0001: C = A & B;
            4'b0010: C = A ^ B;
            4'b0011, 4'b1010, 4'b1101: C = B << shamt;
            4'b0100: begin
                C        = sub_x[WIDTH-1:0];
                Overflow = sub_x[WIDTH] ^ sub_x[WIDTH-1];
            end
            4'b0101: C = A | B;
            4'b0110: C = {B[HW-1:0], {HW{1'b0}}};
            4'b0111: C = B >> shamt;
            4'b1000: C = sub_x[WIDTH-1:0];
            4'b1001: begin
                C        = add_x[WIDTH-1:0];
                Overflow = add_x[WIDTH] ^ add_x[WIDTH-1];
            end
            4'b1011: C = B;
            4'b1110: C = ~(A | B);
            4'b1111: C = $signed(B) >>> shamt;
            default: C = '0;
        endcase
    end

    md_state_t        state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] hi_nx, lo_nx;
    // acc: partial product high half / partial remainder; shreg: multiplier / quotient shifter
    logic [WIDTH-1:0] acc, shreg, mcand, a_raw;
    logic             neg_q, neg_r, dz;
    logic             load, last;
    logic [WIDTH:0]   mul_sum, div_trial;
    logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx, rem_nx, quo_nx;

    assign load = (state == IDLE) && md_start && !md_op[2];
    assign last = (cnt == LAST);
    assign busy = (state != IDLE);

    always_comb begin
        mul_sum                = {1'b0, acc} + {1'b0, (shreg[0] ? mcand : {WIDTH{1'b0}})};
        {mul_hi_nx, mul_lo_nx} = {mul_sum, shreg[WIDTH-1:1]};
        div_trial              = {acc, shreg[WIDTH-1]} - {1'b0, mcand};
        if (!div_trial[WIDTH]) begin
            rem_nx = div_trial[WIDTH-1:0];
            quo_nx = {shreg[WIDTH-2:0], 1'b1};
        end else begin
            rem_nx = {acc[WIDTH-2:0], shreg[WIDTH-1]};
            quo_nx = {shreg[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        hi_nx    = HI;
        lo_nx    = LO;
        case (state)
            IDLE: begin
                if (md_start) begin
                    case (md_op)
                        3'b000, 3'b001: begin state_nx = MUL; cnt_nx = '0; end
                        3'b010, 3'b011: begin state_nx = DIV; cnt_nx = '0; end
                        3'b100: hi_nx = A;
                        3'b101: lo_nx = A;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                cnt_nx = cnt + 1'b1;
                if (last) begin
                    state_nx       = IDLE;
                    cnt_nx         = '0;
                    {hi_nx, lo_nx} = neg_2w({mul_hi_nx, mul_lo_nx}, neg_q);
                end
            end
            DIV: begin
                cnt_nx = cnt + 1'b1;
                if (last) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    if (dz) begin
                        hi_nx = a_raw;
                        lo_nx = '1;
                    end else begin
                        hi_nx = neg_w(rem_nx, neg_r);
                        lo_nx = neg_w(quo_nx, neg_q);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            HI    <= hi_nx;
            LO    <= lo_nx;
        end
    end

    // Operand latch and iteration registers; a reset abort simply leaves them stale.
    always_ff @(posedge clk) begin
        if (load) begin
            acc   <= '0;
            shreg <= magnitude(A, ~md_op[0]);
            mcand <= magnitude(B, ~md_op[0]);
            neg_q <= ~md_op[0] & (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_r <= ~md_op[0] & A[WIDTH-1];
            dz    <= (B == '0);
            a_raw <= A;
        end else if (state == MUL) begin
            acc   <= mul_hi_nx;
            shreg <= mul_lo_nx;
        end else if (state == DIV) begin
            acc   <= rem_nx;
            shreg <= quo_nx;
        end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: WIDTH=32 and WIDTH=16 instances checked every cycle against
// an arithmetic reference model, plus directed literal cases.
module tb_alu_mdu;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] a_in[2];
    logic [31:0] b_in[2];
    logic [3:0]  op_in[2];
    logic        md_start[2];
    logic [2:0]  md_op[2];

    logic [31:0] c32, hi32, lo32;
    logic        ov32, busy32;
    logic [15:0] c16, hi16, lo16;
    logic        ov16, busy16;

    alu_mdu #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(rst_n), .A(a_in[0]), .B(b_in[0]), .Op(op_in[0]),
        .C(c32), .Overflow(ov32), .md_start(md_start[0]), .md_op(md_op[0]),
        .busy(busy32), .HI(hi32), .LO(lo32)
    );

    alu_mdu #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(rst_n), .A(a_in[1][15:0]), .B(b_in[1][15:0]), .Op(op_in[1]),
        .C(c16), .Overflow(ov16), .md_start(md_start[1]), .md_op(md_op[1]),
        .busy(busy16), .HI(hi16), .LO(lo16)
    );

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    logic [63:0]  m_hi[2];
    logic [63:0]  m_lo[2];
    logic [127:0] m_pend[2];
    int           m_left[2];

    function automatic int wid(input int i);
        return (i == 0) ? 32 : 16;
    endfunction

    function automatic logic [63:0] mask_of(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic signed [63:0] sext(input logic [63:0] v, input int w);
        return v[w-1] ? $signed(v | ~mask_of(w)) : $signed(v);
    endfunction

    // {Overflow, C} from the operation table using plain 64-bit arithmetic
    function automatic logic [64:0] alu_model(input int w, input logic [3:0] op,
                                              input logic [31:0] a32, input logic [31:0] b32);
        logic [63:0] m, a, b, r;
        logic signed [63:0] sa, sb, sr, lim;
        int sh;
        logic ov;
        m   = mask_of(w);
        a   = {32'b0, a32} & m;
        b   = {32'b0, b32} & m;
        sa  = sext(a, w);
        sb  = sext(b, w);
        sh  = int'(a32[4:0]) & (w - 1);
        lim = 64'sd1 <<< (w - 1);
        ov  = 1'b0;
        r   = '0;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a & b;
            4'd2:  r = a ^ b;
            4'd3, 4'd10, 4'd13: r = b << sh;
            4'd4:  begin sr = sa - sb; r = sr; ov = (sr >= lim) || (sr < -lim); end
            4'd5:  r = a | b;
            4'd6:  r = b << (w / 2);
            4'd7:  r = b >> sh;
            4'd8:  r = a - b;
            4'd9:  begin sr = sa + sb; r = sr; ov = (sr >= lim) || (sr < -lim); end
            4'd11: r = b;
            4'd12: r = '0;
            4'd14: r = ~(a | b);
            default: begin sr = sb >>> sh; r = sr; end
        endcase
        return {ov, r & m};
    endfunction

    // {HI, LO} result of MULT/MULTU/DIV/DIVU
    function automatic logic [127:0] md_model(input int w, input logic [2:0] op,
                                              input logic [31:0] a32, input logic [31:0] b32);
        logic [63:0] m, a, b, p, hi, lo;
        logic signed [63:0] sa, sb, q, r;
        m  = mask_of(w);
        a  = {32'b0, a32} & m;
        b  = {32'b0, b32} & m;
        sa = sext(a, w);
        sb = sext(b, w);
        hi = '0;
        lo = '0;
        case (op)
            3'd0: begin p = sa * sb; hi = p >> w; lo = p; end
            3'd1: begin p = a * b;   hi = p >> w; lo = p; end
            3'd2: begin
                if (b == 0) begin hi = a; lo = m; end
                else begin q = sa / sb; r = sa % sb; hi = r; lo = q; end
            end
            3'd3: begin
                if (b == 0) begin hi = a; lo = m; end
                else begin hi = a % b; lo = a / b; end
            end
            default: ;
        endcase
        return {hi & m, lo & m};
    endfunction

    function automatic logic [31:0] rand_val(input int w);
        logic [31:0] m, mn;
        m  = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        mn = 32'd1 << (w - 1);
        case ($urandom_range(7))
            0: return 32'd0;
            1: return 32'd1;
            2: return m;
            3: return mn;
            4: return mn - 32'd1;
            5: return 32'($urandom_range(9));
            6: return 32'd2;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        check(name, {96'b0, act}, {96'b0, exp});
    endtask

    // Reference: pending result lands WIDTH edges after acceptance
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_hi[i]   <= '0;
                m_lo[i]   <= '0;
                m_left[i] <= 0;
            end else if (m_left[i] != 0) begin
                m_left[i] <= m_left[i] - 1;
                if (m_left[i] == 1) begin
                    m_hi[i] <= m_pend[i][127:64];
                    m_lo[i] <= m_pend[i][63:0];
                end
            end else if (md_start[i]) begin
                if (!md_op[i][2]) begin
                    m_pend[i] <= md_model(wid(i), md_op[i], a_in[i], b_in[i]);
                    m_left[i] <= wid(i);
                end else if (md_op[i] == 3'b100) begin
                    m_hi[i] <= {32'b0, a_in[i]} & mask_of(wid(i));
                end else if (md_op[i] == 3'b101) begin
                    m_lo[i] <= {32'b0, a_in[i]} & mask_of(wid(i));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy32", {127'b0, busy32}, {127'b0, m_left[0] != 0});
            check("hilo32", {32'b0, hi32, 32'b0, lo32}, {m_hi[0], m_lo[0]});
            check("alu32", {63'b0, ov32, 32'b0, c32}, {63'b0, alu_model(32, op_in[0], a_in[0], b_in[0])});
            check("busy16", {127'b0, busy16}, {127'b0, m_left[1] != 0});
            check("hilo16", {48'b0, hi16, 48'b0, lo16}, {m_hi[1], m_lo[1]});
            check("alu16", {63'b0, ov16, 48'b0, c16}, {63'b0, alu_model(16, op_in[1], a_in[1], b_in[1])});
        end
    end

    task automatic run_md(input int i, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int bc);
        md_start[i] = 1'b1;
        md_op[i]    = op;
        a_in[i]     = a;
        b_in[i]     = b;
        @(posedge clk); #1;
        md_start[i] = 1'b0;
        a_in[i]     = $urandom;
        b_in[i]     = $urandom;
        bc = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if ((i == 0) ? busy32 : busy16) bc++;
            else break;
        end
    endtask

    initial begin
        int bc;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a_in[i]     = 32'h0000_DEAD;
            b_in[i]     = 32'd0;
            op_in[i]    = 4'd0;
            md_start[i] = 1'b1;
            md_op[i]    = 3'b100;
        end
        @(posedge clk); #1;
        cmp_en = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        lit("reset_hi", hi32, 32'h0);
        lit("reset_lo", lo32, 32'h0);
        lit("reset_busy", {31'b0, busy32}, 32'h0);
        rst_n       = 1'b1;
        md_start[0] = 1'b0;
        md_start[1] = 1'b0;

        run_md(0, 3'b000, 32'hFFFF_FFFD, 32'd7, bc);
        lit("mult_busy", bc, 32);
        lit("mult_hi", hi32, 32'hFFFF_FFFF);
        lit("mult_lo", lo32, 32'hFFFF_FFEB);
        run_md(0, 3'b001, 32'hFFFF_FFFD, 32'd7, bc);
        lit("multu_busy", bc, 32);
        lit("multu_hi", hi32, 32'h0000_0006);
        lit("multu_lo", lo32, 32'hFFFF_FFEB);
        run_md(0, 3'b010, 32'hFFFF_FFF9, 32'd2, bc);
        lit("div_lo", lo32, 32'hFFFF_FFFD);
        lit("div_hi", hi32, 32'hFFFF_FFFF);
        run_md(0, 3'b011, 32'd7, 32'd0, bc);
        lit("divz_busy", bc, 32);
        lit("divz_lo", lo32, 32'hFFFF_FFFF);
        lit("divz_hi", hi32, 32'h0000_0007);
        run_md(0, 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, bc);
        lit("divmin_lo", lo32, 32'h8000_0000);
        lit("divmin_hi", hi32, 32'h0);

        md_start[0] = 1'b1; md_op[0] = 3'b101; a_in[0] = 32'h55;
        @(posedge clk); #1;
        md_start[0] = 1'b0;
        lit("mtlo_lo", lo32, 32'h55);
        lit("mtlo_busy", {31'b0, busy32}, 32'h0);

        @(negedge clk); #1;
        op_in[0] = 4'b1001; a_in[0] = 32'h7FFF_FFFF; b_in[0] = 32'd1; #1;
        lit("addov_c", c32, 32'h8000_0000);
        lit("addov_ov", {31'b0, ov32}, 32'd1);
        op_in[0] = 4'b0100; a_in[0] = 32'h8000_0000; #1;
        lit("subov_c", c32, 32'h7FFF_FFFF);
        lit("subov_ov", {31'b0, ov32}, 32'd1);
        op_in[0] = 4'b0000; #1;
        lit("add_ov", {31'b0, ov32}, 32'd0);
        op_in[0] = 4'b1100; #1;
        lit("zero_c", c32, 32'h0);

        md_start[0] = 1'b1; md_op[0] = 3'b010; a_in[0] = 32'hFFFF_FFF9; b_in[0] = 32'd2;
        @(posedge clk); #1;
        md_start[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        md_start[0] = 1'b1; md_op[0] = 3'b100; a_in[0] = 32'h1234;
        @(posedge clk); #1;
        md_start[0] = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy32) break;
        end
        lit("mthi_ign_idle", {31'b0, busy32}, 32'h0);
        lit("mthi_ign_hi", hi32, 32'hFFFF_FFFF);
        lit("mthi_ign_lo", lo32, 32'hFFFF_FFFD);

        md_start[0] = 1'b1; md_op[0] = 3'b000; a_in[0] = 32'd5; b_in[0] = 32'd6;
        @(posedge clk); #1;
        md_start[0] = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        lit("abort_busy_pre", {31'b0, busy32}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        lit("abort_busy", {31'b0, busy32}, 32'h0);
        lit("abort_hi", hi32, 32'h0);
        lit("abort_lo", lo32, 32'h0);
        rst_n = 1'b1;

        run_md(1, 3'b001, 32'h0000_FFFF, 32'h0000_FFFF, bc);
        lit("w16_busy", bc, 16);
        lit("w16_hi", {16'b0, hi16}, 32'h0000_FFFE);
        lit("w16_lo", {16'b0, lo16}, 32'h0000_0001);
        #1;
        op_in[1] = 4'b1111; b_in[1] = 32'h8000; a_in[1] = 32'd4; #1;
        lit("w16_sra", {16'b0, c16}, 32'h0000_F800);
        op_in[1] = 4'b0110; b_in[1] = 32'h00AB; #1;
        lit("w16_lui", {16'b0, c16}, 32'h0000_AB00);

        repeat (3000) begin
            @(posedge clk); #1;
            rst_n = ($urandom_range(499) != 0);
            for (int i = 0; i < 2; i++) begin
                md_start[i] = ($urandom_range(3) == 0);
                md_op[i]    = 3'($urandom_range(7));
                a_in[i]     = rand_val(wid(i));
                b_in[i]     = rand_val(wid(i));
                op_in[i]    = 4'($urandom_range(15));
            end
        end
        @(posedge clk); #1;
        rst_n       = 1'b1;
        md_start[0] = 1'b0;
        md_start[1] = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk); #1;
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
